vga_scanout: RTL and testbench

Raster timing generator and pixel fetch stage that sits directly downstream of the `Frame` pixel store. It sweeps a 640x480@60 VGA raster and maps each visible display pixel to a `Frame` coordinate (`row`, `col`) by integer down-scaling. It reads the 12-bit `Pixel` at that coordinate and drives registered, blanked RGB together with aligned active-low HSYNC/VSYNC to the board VGA connector.

---
 rtl/vga_scanout.sv | 124 ++++++++++++
 tb/tb_vga_scanout.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator with integer down-scaled frame-store fetch and
// registered, blanked RGB plus aligned active-low syncs. Optional feature macro: VGA_TEST_PATTERN_EN.

module vga_scanout #(
  parameter  int CLK_DIV     = 4,
  parameter  int H_VISIBLE   = 640,
  parameter  int H_FRONT     = 16,
  parameter  int H_SYNC      = 96,
  parameter  int H_BACK      = 48,
  parameter  int V_VISIBLE   = 480,
  parameter  int V_FRONT     = 10,
  parameter  int V_SYNC      = 2,
  parameter  int V_BACK      = 33,
  parameter  int SCALE_SHIFT = 2,
  localparam int H_FRAME_HT  = H_VISIBLE >> SCALE_SHIFT,
  localparam int V_FRAME_HT  = V_VISIBLE >> SCALE_SHIFT,
  localparam int COL_W       = $clog2(H_FRAME_HT),
  localparam int ROW_W       = $clog2(V_FRAME_HT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROW_W-1:0] fb_row,
  output logic [COL_W-1:0] fb_col,
  input  logic [11:0]      fb_pixel,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             pattern_sel,
`endif
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_start,
  output logic [9:0]       h_cnt,
  output logic [9:0]       v_cnt
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int DIV_W    = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_vis;
  logic             v_vis;
  logic             hs_active;
  logic             vs_active;
  logic [11:0]      pixel_next;

  assign pix_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap   = (h_cnt == 10'(H_TOTAL - 1));
  assign v_wrap   = (v_cnt == 10'(V_TOTAL - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  assign h_vis     = (h_cnt < 10'(H_VISIBLE));
  assign v_vis     = (v_cnt < 10'(V_VISIBLE));
  assign hs_active = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_START + H_SYNC));
  assign vs_active = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_START + V_SYNC));

  // Blanking parks the address on the last valid index so the store never sees out-of-range reads.
  assign fb_col = h_vis ? COL_W'(h_cnt >> SCALE_SHIFT) : COL_W'(H_FRAME_HT - 1);
  assign fb_row = v_vis ? ROW_W'(v_cnt >> SCALE_SHIFT) : ROW_W'(V_FRAME_HT - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;

  logic [2:0] bar;

  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= 10'(i * BAR_W)) bar = 3'(i);
    end
  end

  // Bar order white..black makes each channel a single inverted bit of the bar index.
  assign pixel_next = pattern_sel ? {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}} : fb_pixel;
`else
  assign pixel_next = fb_pixel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        {vga_r, vga_g, vga_b} <= (h_vis && v_vis) ? pixel_next : 12'h000;
        vga_hs                <= ~hs_active;
        vga_vs                <= ~vs_active;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout on a shrunken raster, compared against
// an arithmetic model of raster position derived from clocks elapsed since reset release.

`timescale 1ns/1ps

module tb_vga_scanout;

  localparam int CLK_DIV = 4;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 32, VF = 2, VS = 2, VB = 2;
  localparam int SS = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LINE_CLK  = HT * CLK_DIV;
  localparam int FRAME_CLK = HT * VT * CLK_DIV;
  localparam int FW = HV >> SS;
  localparam int FH = VV >> SS;
  localparam int COL_W = $clog2(FW);
  localparam int ROW_W = $clog2(FH);
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ROW_W-1:0] fb_row;
  logic [COL_W-1:0] fb_col;
  logic [11:0]      fb_pixel = 12'h000;
  logic [3:0]       vga_r, vga_g, vga_b;
  logic             vga_hs, vga_vs, frame_start;
  logic [9:0]       h_cnt, v_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic             pattern_sel = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int unsigned edges;

  vga_scanout #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SCALE_SHIFT(SS)
  ) dut (
    .clk(clk), .rst(rst), .fb_row(fb_row), .fb_col(fb_col), .fb_pixel(fb_pixel),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release: the model's only time base.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic logic [11:0] mem_word(int row, int col);
    return {4'(row), 4'(col), 4'hA};
  endfunction

  // Frame store model with one clock of read latency.
  always @(posedge clk) fb_pixel <= mem_word(int'(fb_row), int'(fb_col));

  function automatic int pos_h(int unsigned q);
    return int'(q % HT);
  endfunction

  function automatic int pos_v(int unsigned q);
    return int'((q / HT) % VT);
  endfunction

  function automatic logic [11:0] exp_rgb(int unsigned q, bit pattern);
    int h = pos_h(q);
    int v = pos_v(q);
    if (h >= HV || v >= VV) return 12'h000;
    if (pattern) return BARS[h / (HV / 8)];
    return mem_word(v >> SS, h >> SS);
  endfunction

  function automatic logic exp_hs(int unsigned q);
    int h = pos_h(q);
    return !(h >= HV + HF && h < HV + HF + HS);
  endfunction

  function automatic logic exp_vs(int unsigned q);
    int v = pos_v(q);
    return !(v >= VV + VF && v < VV + VF + VS);
  endfunction

  task automatic test_reset();
    int th, tv, n;
    bit found;
    repeat (10) @(negedge clk);
    checks++;
    if ({h_cnt, v_cnt, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start} !== {20'd0, 12'h000, 3'b110}) begin
      errors++;
      $display("FAIL reset_hold: h=%0d v=%0d rgb=%h hs=%b vs=%b fs=%b, required all zero with hs=vs=1",
               h_cnt, v_cnt, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_start);
    end
    rst = 1'b0;
    for (int it = 0; it < 3; it++) begin
      th = (it == 0) ? int'($urandom_range(HV + HF, HV + HF + HS - 1)) : int'($urandom_range(1, HV - 1));
      tv = int'($urandom_range(1, 3));
      found = 0;
      for (int c = 0; c < 6 * LINE_CLK && !found; c++) begin
        @(negedge clk);
        if (h_cnt == 10'(th) && v_cnt == 10'(tv)) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL reset_wait: position (%0d,%0d) not reached, required within %0d clocks", th, tv, 6 * LINE_CLK);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({h_cnt, v_cnt, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start} !== {20'd0, 12'h000, 3'b110}) begin
        errors++;
        $display("FAIL reset_async: h=%0d v=%0d rgb=%h hs=%b vs=%b fs=%b, required immediate reset values",
                 h_cnt, v_cnt, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_start);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int c = 1; c <= 4 * CLK_DIV && n == 0; c++) begin
        @(posedge clk);
        #1;
        if (h_cnt == 10'd1) n = c;
      end
      checks++;
      if (n != CLK_DIV) begin
        errors++;
        $display("FAIL reset_first_tick: h_cnt became 1 after %0d clocks, required %0d", n, CLK_DIV);
      end
    end
  endtask

  task automatic test_datapath(int ncyc);
    int unsigned k, p, q;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;
    int h, v;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      k = edges;
      p = k / CLK_DIV;
      h = pos_h(p);
      v = pos_v(p);
      checks++;
      if (h_cnt !== 10'(h) || v_cnt !== 10'(v)) begin
        errors++;
        $display("FAIL counters at clk %0d: h=%0d v=%0d, required h=%0d v=%0d", k, h_cnt, v_cnt, h, v);
      end
      checks++;
      if (fb_col !== COL_W'(h < HV ? h >> SS : FW - 1) || fb_row !== ROW_W'(v < VV ? v >> SS : FH - 1)) begin
        errors++;
        $display("FAIL address at (%0d,%0d): col=%0d row=%0d, required col=%0d row=%0d", h, v, fb_col, fb_row,
                 h < HV ? h >> SS : FW - 1, v < VV ? v >> SS : FH - 1);
      end
      if (k < CLK_DIV) begin
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        q = p - 1;
        e_rgb = exp_rgb(q, 1'b0); e_hs = exp_hs(q); e_vs = exp_vs(q);
      end
      e_fs = (k > 0) && (k % CLK_DIV == 0) && (p % (HT * VT) == 0);
      checks++;
      if ({vga_r, vga_g, vga_b} !== e_rgb || vga_hs !== e_hs || vga_vs !== e_vs || frame_start !== e_fs) begin
        errors++;
        $display("FAIL outputs at clk %0d: rgb=%h hs=%b vs=%b fs=%b, required rgb=%h hs=%b vs=%b fs=%b",
                 k, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_start, e_rgb, e_hs, e_vs, e_fs);
      end
    end
  endtask

  task automatic test_hsync();
    bit found = 0;
    int low = 0, k_h = -1, k_low = -1;
    for (int c = 0; c < 2 * LINE_CLK && !found; c++) begin
      @(negedge clk);
      if (h_cnt == 10'd0 && edges % CLK_DIV == 0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hsync_align: line start not seen, required within %0d clocks", 2 * LINE_CLK);
    end
    for (int c = 0; c < LINE_CLK; c++) begin
      if (c > 0) @(negedge clk);
      if (h_cnt == 10'(HV + HF) && k_h < 0) k_h = int'(edges);
      if (!vga_hs) begin
        low++;
        if (k_low < 0) k_low = int'(edges);
      end
    end
    checks++;
    if (low != HS * CLK_DIV) begin
      errors++;
      $display("FAIL hsync_width: low for %0d clocks, required %0d", low, HS * CLK_DIV);
    end
    checks++;
    if (k_low - k_h != CLK_DIV) begin
      errors++;
      $display("FAIL hsync_start: low began %0d clocks after sync count, required %0d", k_low - k_h, CLK_DIV);
    end
  endtask

  task automatic test_vsync_frame();
    bit found = 0;
    int low = 0, pulses = 0, k_fs, k_low = -1;
    for (int c = 0; c < FRAME_CLK + 8 && !found; c++) begin
      @(negedge clk);
      if (frame_start) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_wait: no frame_start, required within %0d clocks", FRAME_CLK + 8);
    end
    k_fs = int'(edges);
    for (int c = 0; c < 2 * FRAME_CLK; c++) begin
      @(negedge clk);
      if (!vga_vs) begin
        low++;
        if (k_low < 0) k_low = int'(edges) - k_fs;
      end
      if (frame_start) begin
        pulses++;
        checks++;
        if (int'(edges) - k_fs != FRAME_CLK) begin
          errors++;
          $display("FAIL frame_period: %0d clocks between pulses, required %0d", int'(edges) - k_fs, FRAME_CLK);
        end
        k_fs = int'(edges);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_pulses: %0d pulses in two frames, required 2", pulses);
    end
    checks++;
    if (low != 2 * VS * LINE_CLK) begin
      errors++;
      $display("FAIL vsync_width: low for %0d clocks over two frames, required %0d", low, 2 * VS * LINE_CLK);
    end
    checks++;
    if (k_low != (VV + VF) * LINE_CLK + CLK_DIV) begin
      errors++;
      $display("FAIL vsync_start: low began %0d clocks into frame, required %0d", k_low, (VV + VF) * LINE_CLK + CLK_DIV);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    bit found = 0;
    int unsigned k, p;
    logic [11:0] e_rgb;
    pattern_sel = 1'b1;
    for (int c = 0; c < FRAME_CLK + 8 && !found; c++) begin
      @(negedge clk);
      if (frame_start) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pattern_wait: no frame_start, required within %0d clocks", FRAME_CLK + 8);
    end
    for (int c = 0; c < 2 * LINE_CLK; c++) begin
      @(negedge clk);
      k = edges;
      p = k / CLK_DIV;
      e_rgb = exp_rgb(p - 1, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== e_rgb) begin
        errors++;
        $display("FAIL pattern at h=%0d: rgb=%h, required %h", pos_h(p - 1), {vga_r, vga_g, vga_b}, e_rgb);
      end
    end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_datapath(FRAME_CLK + 2 * LINE_CLK);
    test_hsync();
    test_vsync_frame();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
